hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Decides, every cycle, whether each pipeline register (if_id, id_ex, ex_mem, mem_wb) loads, holds or takes a bubble.
- Detects load-use and branch-operand hazards from the D/E/M instruction words.
- Tracks the multi-cycle mult/div unit with a busy counter and freezes the pipe on variable-latency data-memory waits.

Parameters:
- MULT_CYCLES, 5, cycles mult/multu occupies HI/LO after issue.
- DIV_CYCLES, 10, cycles div/divu occupies HI/LO after issue.
- MEM_TIMEOUT, 255, wait cycles on a single memory access before mem_err is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instrD  input  32  instruction in ID.
- instrE  input  32  instruction in EX.
- instrM  input  32  instruction in MEM.
- md_startE  input  1  EX issues mult/multu/div/divu this cycle.
- md_is_divE  input  1  qualifies md_startE: 1 = div/divu.
- mem_reqM  input  1  MEM stage has an active lw/sw-class access.
- mem_readyM  input  1  data memory completes the access this cycle.
- stallF  output  1  hold PC.
- stallD  output  1  hold if_id.
- flushE  output  1  load nop (32'h0) into id_ex.
- stallE  output  1  hold id_ex.
- stallM  output  1  hold ex_mem.
- flushW  output  1  load nop into mem_wb.
- md_busy  output  1  HI/LO result pending.
- mem_err  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): md counter=0, md_busy=0, mem FSM=IDLE, wait counter=0, mem_err=0. All stall/flush outputs are 0 while in reset and in the cycle after release, given nop instructions.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
  - Load = op in {0x20,0x21,0x23,0x24,0x25}.
  - Branch/jr in D = op 0x04/0x05, or op 0 with funct 0x08.
  - HI/LO user in D = op 0 with funct in {0x10,0x11,0x12,0x13,0x18,0x19,0x1A,0x1B}.
- lu_stall (combinational): E is a load, rtE != 0, and (rsD == rtE or rtD == rtE).
- br_stall (combinational): D is a branch/jr and either:
  - E writes a nonzero dest equal to rsD/rtD (dest = rd for op 0, rt otherwise), or
  - M is a load with rtM != 0 equal to rsD/rtD.
- md_stall = md_busy and D is a HI/LO user.
- Memory FSM, IDLE/WAIT:
  - mem_stall = mem_reqM & ~mem_readyM, combinational; no extra cycle is added when ready is high on the first cycle.
  - IDLE -> WAIT when mem_stall.
  - WAIT -> IDLE when mem_readyM.
  - Wait counter increments each WAIT cycle and clears on exit. On reaching MEM_TIMEOUT, set mem_err (sticky until reset) and keep waiting.
- Output priority:
  1. mem_stall: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0.
  2. else lu_stall | br_stall | md_stall: stallF=stallD=1, flushE=1, stallE=stallM=flushW=0.
  3. else all 0.
- MD counter:
  - On md_startE & ~mem_stall, load MULT_CYCLES or DIV_CYCLES; md_busy=1 from the next cycle.
  - Decrements each cycle, including during mem_stall. md_busy=0 when it reaches 0.
  - md_startE during mem_stall is ignored; the held E instruction re-asserts it when E advances.
  - md_startE while md_busy=1 reloads the counter. This is unreachable in normal flow because D is stalled.
- Counter widths: ceil(log2(max+1)) of the relevant parameter.
- Reset mid-wait or mid-divide aborts immediately to the reset state.

Decomposition:
- Shared package `mips_defs` holds opcode/funct constants (LW, LB, LBU, LH, LHU, BEQ, BNE, JR, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU) and the NOP word.
- One sub-module, `md_busy_cnt`: the MULT/DIV occupancy counter with load/decrement/busy.
- All other logic stays in hazard_ctrl.

Test Plan:
- lw $8 in E (8C080000), add $9,$8,$8 in D -> one cycle with stallF=stallD=flushE=1, then all 0.
- lw $0 in E with D reading $0 -> no stall.
- beq $9,$0 in D, add $9 in E -> one stall cycle. Same with lw $9 in M -> one stall cycle.
- md_startE=1, md_is_divE=1, then mflo in D -> md_busy high exactly 10 cycles. D is stalled through the last busy cycle and released the cycle md_busy falls.
- mem_reqM=1 with mem_readyM low for 3 cycles -> stallF..stallM=1 and flushW=1 for 3 cycles, FSM returns to IDLE. mem_readyM high on the first cycle -> no stall.
- mem_readyM held low 256 cycles -> mem_err=1 after cycle 255 and stays 1. Assert rst=0 mid-wait -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
// Shared MIPS opcode/funct constants, the NOP word, the memory-wait state
// type and small instruction-field decode helpers used by the hazard logic.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_defs;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    // R-type funct codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [5:0] f_op(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Branches and jr need their operands in ID, so they are sensitive to
    // producers still in EX or loads still in MEM.
    function automatic logic is_branch(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_RTYPE) && (instr[5:0] == FN_JR));
    endfunction

    function automatic logic is_hilo_user(input logic [31:0] instr);
        logic [5:0] fn;
        fn = instr[5:0];
        return (instr[31:26] == OP_RTYPE) &&
               ((fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
                (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
                (fn == FN_DIV)  || (fn == FN_DIVU));
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// ---------------------------------------------------------------------------
// md_busy_cnt
// Occupancy counter for the multi-cycle mult/div unit. A load sets the
// counter to the operation latency; it then counts down to zero and busy is
// high whenever the count is nonzero.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   load    start an operation this cycle
//   is_div  selects the divide latency for load
//   busy    HI/LO result still pending
// ---------------------------------------------------------------------------
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_V = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_V  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // A load always wins, so a restart while busy simply reloads the latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= is_div ? DIV_V : MULT_V;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE_V;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use,
// branch-operand and HI/LO hazards from the D/E/M instruction words, tracks
// the mult/div unit occupancy and freezes the pipe on data-memory waits.
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   instrD/E/M               instruction words in ID, EX, MEM
//   md_startE, md_is_divE    mult/div issue from EX and its kind
//   mem_reqM, mem_readyM     data-memory access handshake from MEM
//   stallF/D/E/M             hold PC / if_id / id_ex / ex_mem
//   flushE, flushW           bubble into id_ex / mem_wb
//   md_busy                  HI/LO result pending
//   mem_err                  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module hazard_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] instrE,
    input  logic [31:0] instrM,
    input  logic        md_startE,
    input  logic        md_is_divE,
    input  logic        mem_reqM,
    input  logic        mem_readyM,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        stallE,
    output logic        stallM,
    output logic        flushW,
    output logic        md_busy,
    output logic        mem_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    logic [4:0]  rs_d, rt_d, rt_e, rt_m, dest_e;
    logic        mem_stall, lu_stall, br_stall, md_stall;
    logic        md_load;
    mem_state_t  mem_state;
    logic [WAIT_W-1:0] wait_cnt;

    assign rs_d = f_rs(instrD);
    assign rt_d = f_rt(instrD);
    assign rt_e = f_rt(instrE);
    assign rt_m = f_rt(instrM);

    // EX writes rd for R-type and rt for everything else.
    assign dest_e = (f_op(instrE) == OP_RTYPE) ? f_rd(instrE) : rt_e;

    // Hazard terms are qualified with rst so every stall/flush drops the
    // moment reset is asserted, not at the next clock.
    assign mem_stall = rst & mem_reqM & ~mem_readyM;

    assign lu_stall = rst & is_load(instrE) & (rt_e != 5'd0) &
                      ((rs_d == rt_e) | (rt_d == rt_e));

    assign br_stall = rst & is_branch(instrD) &
                      (((dest_e != 5'd0) & ((dest_e == rs_d) | (dest_e == rt_d))) |
                       (is_load(instrM) & (rt_m != 5'd0) &
                        ((rt_m == rs_d) | (rt_m == rt_d))));

    assign md_stall = rst & md_busy & is_hilo_user(instrD);

    // An issue that coincides with a memory freeze is dropped; the held EX
    // instruction raises md_startE again once the pipe moves.
    assign md_load = md_startE & ~mem_stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (md_load),
        .is_div (md_is_divE),
        .busy   (md_busy)
    );

    // Memory wait tracking. wait_cnt holds the number of stalled cycles of
    // the current access; mem_err latches once it reaches the timeout and
    // the pipe keeps waiting. Leaving the stall condition ends the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_state <= MEM_IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (mem_stall) begin
                        mem_state <= MEM_WAIT;
                        wait_cnt  <= WAIT_ONE;
                        if (TIMEOUT_M1 == '0) begin
                            mem_err <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        mem_state <= MEM_IDLE;
                        wait_cnt  <= '0;
                    end else begin
                        if (wait_cnt != TIMEOUT_V) begin
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                        if (wait_cnt >= TIMEOUT_M1) begin
                            mem_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    mem_state <= MEM_IDLE;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    // A memory freeze outranks the decode hazards: everything up to MEM
    // holds and WB gets a bubble. Decode hazards hold F/D and bubble EX.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushE = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushW = 1'b0;
        if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (lu_stall | br_stall | md_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed and randomized stimulus for hazard_ctrl, checked against a
// behavioural model of the stall/flush rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instrD, instrE, instrM;
    logic        md_startE, md_is_divE, mem_reqM, mem_readyM;
    logic        stallF, stallD, flushE, stallE, stallM, flushW, md_busy, mem_err;

    int checks = 0;
    int errors = 0;
    int busyCycles = 0;

    // Reference model state: remaining mult/div cycles, stalled cycles of the
    // current memory access, and the sticky timeout flag.
    int mdLeft = 0;
    int waitN  = 0;
    bit errM   = 0;

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .MEM_TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instrD     (instrD),
        .instrE     (instrE),
        .instrM     (instrM),
        .md_startE  (md_startE),
        .md_is_divE (md_is_divE),
        .mem_reqM   (mem_reqM),
        .mem_readyM (mem_readyM),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushE     (flushE),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushW     (flushW),
        .md_busy    (md_busy),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit mLoad(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        return op == 'h20 || op == 'h21 || op == 'h23 || op == 'h24 || op == 'h25;
    endfunction

    // Expected outputs in the order {F,D,flushE,E,M,flushW,busy,err}.
    function automatic logic [7:0] expectOutputs();
        int rsD, rtD, rtE, rtM, destE, fnD, opD;
        bit isBr, isHilo, lu, br, md, memS;
        logic [7:0] r;
        opD = int'(instrD[31:26]);
        fnD = int'(instrD[5:0]);
        rsD = int'(instrD[25:21]);
        rtD = int'(instrD[20:16]);
        rtE = int'(instrE[20:16]);
        rtM = int'(instrM[20:16]);
        destE = (instrE[31:26] == 6'd0) ? int'(instrE[15:11]) : rtE;
        isBr = opD == 4 || opD == 5 || (opD == 0 && fnD == 8);
        isHilo = opD == 0 && ((fnD >= 'h10 && fnD <= 'h13) || (fnD >= 'h18 && fnD <= 'h1B));
        lu = mLoad(instrE) && rtE != 0 && (rsD == rtE || rtD == rtE);
        br = isBr && ((destE != 0 && (destE == rsD || destE == rtD)) ||
                      (mLoad(instrM) && rtM != 0 && (rtM == rsD || rtM == rtD)));
        md = (mdLeft > 0) && isHilo;
        memS = mem_reqM && !mem_readyM;
        if (memS)               r = 8'b1101_1100;
        else if (lu || br || md) r = 8'b1110_0000;
        else                    r = 8'b0000_0000;
        r[1] = (mdLeft > 0);
        r[0] = errM;
        return r;
    endfunction

    task automatic modelAdvance();
        bit memS;
        memS = mem_reqM && !mem_readyM;
        if (md_startE && !memS) mdLeft = md_is_divE ? 10 : 5;
        else if (mdLeft > 0)    mdLeft--;
        if (memS) begin
            waitN++;
            if (waitN >= 255) errM = 1;
        end else begin
            waitN = 0;
        end
    endtask

    task automatic modelReset();
        mdLeft = 0;
        waitN  = 0;
        errM   = 0;
    endtask

    task automatic checkOutput(input logic [7:0] e);
        chk("stallF",  stallF,  e[7]);
        chk("stallD",  stallD,  e[6]);
        chk("flushE",  flushE,  e[5]);
        chk("stallE",  stallE,  e[4]);
        chk("stallM",  stallM,  e[3]);
        chk("flushW",  flushW,  e[2]);
        chk("md_busy", md_busy, e[1]);
        chk("mem_err", mem_err, e[0]);
        if (md_busy === 1'b1) busyCycles++;
    endtask

    // One clock cycle: drive inputs just after a rising edge, check outputs
    // at the falling edge, then advance the model on the next rising edge.
    task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e,
                                 input logic [31:0] m, input logic st,
                                 input logic dv, input logic rq, input logic rd);
        logic [7:0] expv;
        instrD = d; instrE = e; instrM = m;
        md_startE = st; md_is_divE = dv;
        mem_reqM = rq; mem_readyM = rd;
        expv = expectOutputs();
        @(negedge clk);
        checkOutput(expv);
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic checkResetState(input string tag);
        $display("[TB] reset check: %s", tag);
        checkOutput(8'h00);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [4:0]  a, b, c;
        int k;
        w = $urandom;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 5);
        w[25:21] = a;
        w[20:16] = b;
        case (k)
            0: begin w[31:26] = 6'h00; w[15:11] = c; w[5:0] = 6'h20; end
            1: w[31:26] = 6'($urandom_range(0, 1) == 1 ? 'h23 : 'h20 + $urandom_range(0, 5) % 2);
            2: w[31:26] = 6'($urandom_range(4, 5));
            3: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            4: begin w[31:26] = 6'h00; w[15:11] = c; w[5:0] = 6'($urandom_range('h10, 'h13)); end
            default: w[31:26] = 6'h2B;
        endcase
        return w;
    endfunction

    localparam logic [31:0] LW8   = 32'h8C08_0000;
    localparam logic [31:0] LW0   = 32'h8C00_0000;
    localparam logic [31:0] LW9   = 32'h8C09_0000;
    localparam logic [31:0] ADD98 = 32'h0108_4820;
    localparam logic [31:0] ADD90 = 32'h0000_4820;
    localparam logic [31:0] BEQ9  = 32'h1120_0000;
    localparam logic [31:0] DIV89 = 32'h0109_001A;
    localparam logic [31:0] MFLO  = 32'h0000_5012;

    initial begin
        // Asynchronous reset with hazards present on every input.
        rst = 1'b0;
        instrD = ADD98; instrE = LW8; instrM = LW9;
        md_startE = 1'b1; md_is_divE = 1'b1;
        mem_reqM = 1'b1; mem_readyM = 1'b0;
        #3;
        checkResetState("in reset");
        #3;
        instrD = 32'h0; instrE = 32'h0; instrM = 32'h0;
        md_startE = 1'b0; md_is_divE = 1'b0; mem_reqM = 1'b0; mem_readyM = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        modelReset();

        $display("[TB] nop after reset");
        applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] load-use");
        applyStimulus(ADD98, LW8, 32'h0, 0, 0, 0, 0);
        applyStimulus(ADD98, 32'h0, LW8, 0, 0, 0, 0);

        $display("[TB] load to $0");
        applyStimulus(ADD90, LW0, 32'h0, 0, 0, 0, 0);

        $display("[TB] branch operand hazards");
        applyStimulus(BEQ9, ADD98, 32'h0, 0, 0, 0, 0);
        applyStimulus(BEQ9, 32'h0, ADD98, 0, 0, 0, 0);
        applyStimulus(BEQ9, 32'h0, LW9, 0, 0, 0, 0);
        applyStimulus(BEQ9, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] divide occupancy");
        busyCycles = 0;
        applyStimulus(MFLO, DIV89, 32'h0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(MFLO, 32'h0, 32'h0, 0, 0, 0, 0);
        chkInt("div_busy_cycles", busyCycles, 10);

        $display("[TB] multiply occupancy");
        busyCycles = 0;
        applyStimulus(32'h0, 32'h0109_0018, 32'h0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(MFLO, 32'h0, 32'h0, 0, 0, 0, 0);
        chkInt("mult_busy_cycles", busyCycles, 5);

        $display("[TB] memory wait of 3 cycles");
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 0);
        applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 1);
        applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 1);
        applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] issue during memory wait is ignored");
        applyStimulus(32'h0, DIV89, LW8, 1, 1, 1, 0);
        applyStimulus(32'h0, DIV89, LW8, 1, 1, 1, 1);
        applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] memory timeout");
        for (int i = 0; i < 256; i++) applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 0);
        applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] reset during divide and memory wait");
        applyStimulus(32'h0, DIV89, 32'h0, 1, 1, 0, 0);
        applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 0);
        applyStimulus(32'h0, 32'h0, LW8, 0, 0, 1, 0);
        #2 rst = 1'b0;
        #1 checkResetState("mid wait");
        instrE = 32'h0; instrM = 32'h0; mem_reqM = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        modelReset();
        applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(randInstr(), randInstr(), randInstr(),
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
